// File: rtl/i2c_pkg.sv
// i2c_pkg: shared speed-mode encodings, rate constants, SCL FSM states and half-period helper
package i2c_pkg;
  localparam logic [2:0] MODE_SM     = 3'b000;
  localparam logic [2:0] MODE_FM     = 3'b001;
  localparam logic [2:0] MODE_FMP    = 3'b010;
  localparam logic [2:0] MODE_HS     = 3'b011;
  localparam logic [2:0] MODE_CUSTOM = 3'b100;
  localparam int unsigned RATE_SM  = 100_000;
  localparam int unsigned RATE_FM  = 400_000;
  localparam int unsigned RATE_FMP = 1_000_000;
  localparam int unsigned RATE_HS  = 3_400_000;
  localparam int unsigned HALF_MIN  = 4;
  localparam int unsigned SYNC_COMP = 3;
  typedef enum logic [1:0] {IDLE, LOW, WAIT, HIGH} scl_state_e;
  function automatic int unsigned half_cycles(input int unsigned sys_clock, input int unsigned rate);
    int unsigned h;
    h = sys_clock / (2 * rate);
    return h < HALF_MIN ? HALF_MIN : h;
  endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchroniser for an open-drain line, idles released (1)
module i2c_line_sync (
  input  logic Clk_In,
  input  logic Reset_N_In,
  input  logic Line_In,
  output logic Line_Sync_Out
);
  logic meta;
  always_ff @(posedge Clk_In)
    if (!Reset_N_In) {Line_Sync_Out, meta} <= 2'b11;
    else {Line_Sync_Out, meta} <= {meta, Line_In};
endmodule

// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator: glitch-free SCL generator with phase strobes, clock stretching and stretch timeout
module i2c_scl_generator
  import i2c_pkg::*;
#(
  parameter int unsigned SYS_CLOCK   = 100_000_000,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter int unsigned STRETCH_MAX = 65535
) (
  input  logic                 Clk_In,
  input  logic                 Reset_N_In,
  input  logic                 Enable_In,
  input  logic [2:0]           Speed_Mode_In,
  input  logic [CNT_WIDTH-1:0] Custom_Half_In,
  input  logic                 Scl_In,
  output logic                 Scl_Drive_Low_Out,
  output logic                 Scl_Fall_Out,
  output logic                 Data_Change_Out,
  output logic                 Scl_Rise_Out,
  output logic                 Data_Sample_Out,
  output logic                 Stretch_Out,
  output logic                 Timeout_Out,
  output logic                 Busy_Out,
  output logic [2:0]           Active_Mode_Out
);
  localparam int unsigned WAIT_WIDTH = $clog2(STRETCH_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] HALF_SM  = CNT_WIDTH'(half_cycles(SYS_CLOCK, RATE_SM));
  localparam logic [CNT_WIDTH-1:0] HALF_FM  = CNT_WIDTH'(half_cycles(SYS_CLOCK, RATE_FM));
  localparam logic [CNT_WIDTH-1:0] HALF_FMP = CNT_WIDTH'(half_cycles(SYS_CLOCK, RATE_FMP));
  localparam logic [CNT_WIDTH-1:0] HALF_HS  = CNT_WIDTH'(half_cycles(SYS_CLOCK, RATE_HS));
  scl_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, half_q, half_d, half_sel, half_custom;
  logic [WAIT_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [2:0] mode_sel;
  logic latch, timeout_d, scl_s;
  i2c_line_sync u_scl_sync (
    .Clk_In        (Clk_In),
    .Reset_N_In    (Reset_N_In),
    .Line_In       (Scl_In),
    .Line_Sync_Out (scl_s)
  );
  assign mode_sel    = Speed_Mode_In > MODE_CUSTOM ? MODE_FM : Speed_Mode_In;
  assign half_custom = Custom_Half_In < CNT_WIDTH'(HALF_MIN) ? CNT_WIDTH'(HALF_MIN) : Custom_Half_In;
  assign half_sel    = mode_sel == MODE_SM     ? HALF_SM  :
                       mode_sel == MODE_FMP    ? HALF_FMP :
                       mode_sel == MODE_HS     ? HALF_HS  :
                       mode_sel == MODE_CUSTOM ? half_custom : HALF_FM;
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    wcnt_d    = '0;
    latch     = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (Enable_In) begin
        state_d = LOW;
        latch   = 1'b1;
      end
      LOW: if (cnt_q == half_q - 1'b1) state_d = WAIT;
           else cnt_d = cnt_q + 1'b1;
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (scl_s) begin
          state_d = HIGH;
          wcnt_d  = '0;
        end else if (wcnt_d == WAIT_WIDTH'(STRETCH_MAX)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
          wcnt_d    = '0;
        end
      end
      HIGH: if (cnt_q == half_q - CNT_WIDTH'(SYNC_COMP + 1)) begin
        state_d = Enable_In ? LOW : IDLE;
        latch   = Enable_In;
      end else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
    half_d = latch ? half_sel : half_q;
  end
  // Strobes are decoded from next state so every output comes straight off a flop
  always_ff @(posedge Clk_In)
    if (!Reset_N_In) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      wcnt_q            <= '0;
      half_q            <= HALF_FM;
      Scl_Drive_Low_Out <= 1'b0;
      Scl_Fall_Out      <= 1'b0;
      Data_Change_Out   <= 1'b0;
      Scl_Rise_Out      <= 1'b0;
      Data_Sample_Out   <= 1'b0;
      Stretch_Out       <= 1'b0;
      Timeout_Out       <= 1'b0;
      Busy_Out          <= 1'b0;
      Active_Mode_Out   <= MODE_FM;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      wcnt_q            <= wcnt_d;
      half_q            <= half_d;
      Scl_Drive_Low_Out <= state_d == LOW;
      Scl_Fall_Out      <= latch;
      Data_Change_Out   <= state_d == LOW && cnt_d == (half_d >> 1);
      Scl_Rise_Out      <= state_q == WAIT && state_d == HIGH;
      Data_Sample_Out   <= state_d == HIGH && cnt_d == ((half_q - CNT_WIDTH'(SYNC_COMP)) >> 1);
      Stretch_Out       <= state_d == WAIT && wcnt_d >= WAIT_WIDTH'(SYNC_COMP);
      Timeout_Out       <= timeout_d;
      Busy_Out          <= state_d != IDLE;
      Active_Mode_Out   <= latch ? mode_sel : Active_Mode_Out;
    end
endmodule

// File: tb/tb_i2c_scl_generator.sv
// tb_i2c_scl_generator: scoreboard bench predicting every SCL strobe cycle and checking levels at key points
module tb_i2c_scl_generator;
  typedef struct {int kind; int cyc;} ev_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, hold = 1'b0, stuck = 1'b0;
  logic [2:0] mode = 3'b001;
  logic [15:0] custom = '0;
  logic scl_pad, drive, fall, chg, rise, samp, stretch, tmo, busy;
  logic [2:0] amode;
  int cyc = 0, n_checks = 0, n_errors = 0, n_stretch = 0;
  int nf, t_fall, t_rise, r2, r3, f3, f4, f5, r5, f6, t0;
  ev_t sb[$];
  assign scl_pad = !drive && !hold && !stuck;
  i2c_scl_generator #(.SYS_CLOCK(100_000_000), .CNT_WIDTH(16), .STRETCH_MAX(1000)) dut (
    .Clk_In(clk), .Reset_N_In(rst_n), .Enable_In(en), .Speed_Mode_In(mode),
    .Custom_Half_In(custom), .Scl_In(scl_pad), .Scl_Drive_Low_Out(drive),
    .Scl_Fall_Out(fall), .Data_Change_Out(chg), .Scl_Rise_Out(rise),
    .Data_Sample_Out(samp), .Stretch_Out(stretch), .Timeout_Out(tmo),
    .Busy_Out(busy), .Active_Mode_Out(amode)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask
  task automatic plan(input int h, input int s);
    t_fall = nf;
    push(0, nf);
    push(1, nf + h / 2);
    t_rise = nf + h + 3 + s;
    push(2, t_rise);
    push(3, t_rise + (h - 3) / 2);
    nf = t_rise + h - 3;
  endtask
  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_drive"}, int'(drive), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_stretch"}, int'(stretch), 0);
    check({tag, "_pulses"}, int'({fall, chg, rise, samp, tmo}), 0);
    check({tag, "_mode"}, int'(amode), 1);
  endtask
  always @(negedge clk) begin : monitor
    logic [4:0] p;
    ev_t e;
    if (stretch) n_stretch++;
    p = {tmo, samp, rise, chg, fall};
    if (rst_n)
      for (int k = 0; k < 5; k++)
        if (p[k]) begin
          if (sb.size() == 0) check("unexpected_event", k, -1);
          else begin
            e = sb.pop_front();
            check("event_kind", k, e.kind);
            check("event_cycle", cyc, e.cyc);
          end
        end
  end
  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    nf = cyc + 1;
    plan(125, 0);
    plan(125, 0);
    r2 = t_rise;
    plan(500, 0);
    f3 = t_fall;
    r3 = t_rise;
    plan(4, 0);
    f4 = t_fall;
    plan(125, 40);
    f5 = t_fall;
    r5 = t_rise;
    plan(125, 0);
    f6 = t_fall;
    en = 1'b1;
    wait_cyc(cyc + 1);
    check("first_low_drive", int'(drive), 1);
    check("first_low_busy", int'(busy), 1);
    wait_cyc(r2 + 10);
    mode = 3'b000;
    check("mode_held_mid_high", int'(amode), 1);
    wait_cyc(f3 + 5);
    check("mode_sm_latched", int'(amode), 0);
    check("sm_low_drive", int'(drive), 1);
    wait_cyc(r3 + 10);
    mode = 3'b100;
    custom = 16'd1;
    wait_cyc(f4 + 1);
    check("mode_custom_latched", int'(amode), 4);
    mode = 3'b001;
    wait_cyc(f5 + 10);
    hold = 1'b1;
    wait_cyc(f5 + 125 + 20);
    check("stretch_during_hold", int'(stretch), 1);
    check("released_during_hold", int'(drive), 0);
    wait_cyc(f5 + 125 + 40);
    hold = 1'b0;
    wait_cyc(r5 + 5);
    check("stretch_cleared", int'(stretch), 0);
    wait_cyc(f6 + 10);
    en = 1'b0;
    wait_cyc(nf);
    check("disabled_drive", int'(drive), 0);
    check("disabled_busy", int'(busy), 0);
    wait_cyc(nf + 20);
    check("stretch_cycles", n_stretch, 40);
    stuck = 1'b1;
    en = 1'b1;
    t0 = cyc + 1;
    push(0, t0);
    push(1, t0 + 62);
    push(4, t0 + 125 + 1000);
    wait_cyc(t0 + 5);
    en = 1'b0;
    wait_cyc(t0 + 125 + 500);
    check("stuck_stretch", int'(stretch), 1);
    wait_cyc(t0 + 125 + 1000);
    check("timeout_drive", int'(drive), 0);
    check("timeout_busy", int'(busy), 0);
    wait_cyc(t0 + 125 + 1010);
    check("timeout_idle", int'(busy), 0);
    stuck = 1'b0;
    mode = 3'b000;
    en = 1'b1;
    t0 = cyc + 1;
    push(0, t0);
    wait_cyc(t0 + 5);
    check("pre_reset_mode", int'(amode), 0);
    check("pre_reset_drive", int'(drive), 1);
    rst_n = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_low_reset");
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_after_reset", int'(busy), 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
